// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter: wrap, saturate and one-shot modes with registered tc.
// Optional tick prescaler enabled by defining COUNTER_PRESCALE_EN (adds the prescale port).
module updown_mod_counter #(
    parameter int WIDTH      = 8,
    parameter int STEP_W     = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  load_en,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  dir,
    input  logic [STEP_W-1:0]     step,
    input  logic [WIDTH-1:0]      limit,
    input  logic [1:0]            mode,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  running
);

    // Two guard bits keep count+step and count-step exact.
    localparam int EW = WIDTH + 2;

    typedef enum logic {RUN, HALT} state_t;

    if (WIDTH < 1 || STEP_W < 1 || STEP_W > EW || PRESCALE_W < 1) begin : g_param_check
        $error("updown_mod_counter: illegal parameter combination");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             tick;

    logic [EW-1:0] cnt_x, step_x, lim_x, bound_x;
    logic [EW-1:0] sum_x, diff_x, next_x;
    logic          wrap_m, bnd, tc_ev;

    function automatic logic [EW-1:0] fold_up(input logic [EW-1:0] sum,
                                              input logic [EW-1:0] lim,
                                              input logic          wrap);
        if (sum > lim)
            return wrap ? sum - (lim + EW'(1)) : lim;
        return sum;
    endfunction

    function automatic logic [EW-1:0] fold_down(input logic [EW-1:0] diff,
                                                input logic [EW-1:0] lim,
                                                input logic          neg,
                                                input logic          wrap);
        if (neg)
            return wrap ? diff + lim + EW'(1) : '0;
        return diff;
    endfunction

`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] presc_q, presc_d;

    assign tick = en && (presc_q == prescale);

    always_comb begin
        presc_d = presc_q;
        if (clr || load_en)
            presc_d = '0;
        else if (en)
            presc_d = tick ? '0 : presc_q + PRESCALE_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            presc_q <= '0;
        else
            presc_q <= presc_d;
    end
`else
    assign tick = en;
`endif

    assign cnt_x   = EW'(count_q);
    assign step_x  = EW'(step);
    assign lim_x   = EW'(limit);
    assign bound_x = dir ? lim_x : '0;
    assign wrap_m  = (mode == 2'b00) || (mode == 2'b11);
    assign sum_x   = cnt_x + step_x;
    assign diff_x  = cnt_x - step_x;
    assign bnd     = dir ? (sum_x >= lim_x) : (cnt_x <= step_x);
    assign next_x  = dir ? fold_up(sum_x, lim_x, wrap_m)
                         : fold_down(diff_x, lim_x, cnt_x < step_x, wrap_m);
    // Clamping modes flag only the arrival at the bound, not sitting on it.
    assign tc_ev   = wrap_m ? bnd : ((next_x == bound_x) && (cnt_x != bound_x));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        if (clr) begin
            count_d = '0;
            state_d = RUN;
        end else if (load_en) begin
            count_d = (load_val > limit) ? limit : load_val;
            state_d = RUN;
        end else if (tick && state_q == RUN) begin
            count_d = next_x[WIDTH-1:0];
            tc_d    = tc_ev;
            if (mode == 2'b10 && tc_ev)
                state_d = HALT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count   = count_q;
    assign tc      = tc_q;
    assign running = (state_q == RUN);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter; an integer reference model predicts count/tc/running.
// Exercises the prescaler too when COUNTER_PRESCALE_EN is defined.
module tb_updown_mod_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, clr = 1'b0, load_en = 1'b0, dir = 1'b1;
    logic [7:0] load_val = '0, limit = 8'd9;
    logic [3:0] step = 4'd1;
    logic [1:0] mode = 2'b00;
    logic [7:0] prescale = '0;
    logic [7:0] count;
    logic       tc, running;

    typedef struct packed {
        logic [7:0] c;
        logic       t;
        logic       r;
    } exp_t;

    exp_t  sbq[$];
    int    n_checks = 0;
    int    n_errors = 0;
    string phase = "reset";

    int m_cnt = 0, m_pre = 0;
    bit m_tc = 1'b0, m_run = 1'b1;

    always #5 clk = ~clk;

    updown_mod_counter #(.WIDTH(8), .STEP_W(4), .PRESCALE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load_en(load_en),
        .load_val(load_val), .dir(dir), .step(step), .limit(limit), .mode(mode),
`ifdef COUNTER_PRESCALE_EN
        .prescale(prescale),
`endif
        .count(count), .tc(tc), .running(running)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // Reference model: applies one clock edge with the inputs currently driven.
    task automatic model_advance();
        int  c, s, L, n, pv, bound;
        bit  tk, b, wrapm;
        c = m_cnt; s = int'(step); L = int'(limit);
`ifdef COUNTER_PRESCALE_EN
        pv = int'(prescale);
`else
        pv = 0;
`endif
        if (clr) begin
            m_cnt = 0; m_tc = 0; m_run = 1; m_pre = 0;
        end else if (load_en) begin
            m_cnt = (int'(load_val) > L) ? L : int'(load_val);
            m_tc = 0; m_run = 1; m_pre = 0;
        end else begin
            tk = en && (m_pre == pv);
            if (en) m_pre = tk ? 0 : (m_pre + 1) % 256;
            m_tc = 0;
            if (tk && m_run) begin
                wrapm = !(mode == 2'b01 || mode == 2'b10);
                if (dir) begin
                    n = c + s; b = (n >= L); bound = L;
                    if (n > L) n = wrapm ? n - (L + 1) : L;
                end else begin
                    n = c - s; b = (c <= s); bound = 0;
                    if (n < 0) n = wrapm ? n + (L + 1) : 0;
                end
                m_tc  = wrapm ? b : (n == bound && c != bound);
                m_cnt = n & 255;
                if (mode == 2'b10 && m_tc) m_run = 0;
            end
        end
    endtask

    task automatic step_cycle();
        exp_t e;
        model_advance();
        sbq.push_back({m_cnt[7:0], m_tc, m_run});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({phase, ".count"}, int'(count), int'(e.c));
        chk({phase, ".tc"}, int'(tc), int'(e.t));
        chk({phase, ".running"}, int'(running), int'(e.r));
        clr = 1'b0;
        load_en = 1'b0;
    endtask

    initial begin
        int seq_dw[6];
        int cap;
        seq_dw = '{2, 9, 6, 3, 0, 7};

        #12;
        chk("reset.count", int'(count), 0);
        chk("reset.tc", int'(tc), 0);
        chk("reset.running", int'(running), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        phase = "upwrap";
        limit = 9; step = 1; dir = 1; mode = 2'b00; clr = 1;
        step_cycle();
        en = 1;
        for (int i = 1; i <= 25; i++) begin
            step_cycle();
            chk("upwrap.seq", int'(count), i % 10);
        end

        phase = "downwrap";
        dir = 0; step = 3; load_val = 2; load_en = 1;
        step_cycle();
        chk("downwrap.seq", int'(count), seq_dw[0]);
        for (int i = 1; i < 6; i++) begin
            step_cycle();
            chk("downwrap.seq", int'(count), seq_dw[i]);
        end

        phase = "sat";
        mode = 2'b01; dir = 1; limit = 200; step = 15; load_val = 190; load_en = 1;
        step_cycle();
        for (int i = 0; i < 3; i++) begin
            step_cycle();
            chk("sat.seq", int'(count), 200);
        end

        phase = "oneshot";
        mode = 2'b10; limit = 5; step = 1; clr = 1;
        step_cycle();
        for (int i = 0; i < 8; i++) step_cycle();
        chk("oneshot.hold", int'(count), 5);
        chk("oneshot.halted", int'(running), 0);
        mode = 2'b00;
        for (int i = 0; i < 2; i++) step_cycle();
        mode = 2'b10; load_val = 2; load_en = 1;
        step_cycle();
        chk("oneshot.reload", int'(count), 2);

        phase = "priority";
        mode = 2'b00; limit = 100; load_val = 50; clr = 1; load_en = 1;
        step_cycle();
        chk("priority.clr_wins", int'(count), 0);
        load_val = 250; load_en = 1;
        step_cycle();
        chk("priority.clamp", int'(count), 100);

        phase = "limit0";
        limit = 0; step = 1; clr = 1;
        step_cycle();
        for (int i = 0; i < 4; i++) begin
            dir = i[0];
            step_cycle();
        end

        phase = "step0";
        limit = 9; step = 0; dir = 1; load_val = 4; load_en = 1;
        step_cycle();
        for (int i = 0; i < 3; i++) step_cycle();

        phase = "random";
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(15) == 0) limit = 8'($urandom_range(255));
            cap = (int'(limit) + 1 > 15) ? 15 : int'(limit) + 1;
            step = 4'($urandom_range(cap));
            mode = 2'($urandom_range(3));
            dir = 1'($urandom_range(1));
            en = ($urandom_range(3) != 0);
            clr = ($urandom_range(31) == 0);
            load_en = ($urandom_range(15) == 0);
            load_val = 8'($urandom_range(255));
`ifdef COUNTER_PRESCALE_EN
            if ($urandom_range(31) == 0) prescale = 8'($urandom_range(3));
`endif
            step_cycle();
        end
        prescale = 0;

        phase = "async";
        en = 1; mode = 2'b00; limit = 9; step = 1; dir = 1; clr = 1;
        step_cycle();
        for (int i = 0; i < 7; i++) step_cycle();
        chk("async.before", int'(count), 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async.count", int'(count), 0);
        chk("async.tc", int'(tc), 0);
        chk("async.running", int'(running), 1);
        m_cnt = 0; m_tc = 0; m_run = 1; m_pre = 0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step_cycle();

`ifdef COUNTER_PRESCALE_EN
        phase = "prescale";
        prescale = 3; clr = 1;
        step_cycle();
        for (int i = 0; i < 12; i++) step_cycle();
        chk("prescale.count", int'(count), 3);
        prescale = 0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
